key_input_conditioner: RTL and testbench

- Front-end stage that turns raw note buttons and octave switches into the clean 10-bit note_and_pitch word used by the learning and free-play stages.
- Word format: one-hot note in [9:3], pitch in [2:0]. An all-zero word means "no key held".
- Performs synchronisation, per-bit debounce and first-pressed-wins key arbitration.
- Always inserts an all-zero gap between two notes, so downstream re-arm logic that waits for note==0 always sees a release.

---
 rtl/key_input_conditioner.sv | 157 +++++++++++++++
 tb/tb_key_input_conditioner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
// Key input conditioner: turns raw note buttons and pitch switches into a
// clean one-hot note + pitch word. Each raw bit goes through a 2-FF
// synchroniser and a counter debouncer. A three-state FSM then picks the
// first-pressed key and guarantees an all-zero gap between two notes.

module key_input_conditioner_deb #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int CNT_W           = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic             s1, s2, deb;
    logic [CNT_W-1:0] cnt;

    assign dout = deb;

    // Synchronise, then accept a new level only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module key_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int CNT_W           = 21,
    parameter int GAP_CYCLES      = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] note_keys,
    input  logic [2:0] pitch_sw,
    output logic [9:0] note_and_pitch,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       multi_key
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, HELD, GAP} state_t;

    logic [9:0] raw_vec, deb_vec;
    logic [6:0] deb_note, lowest;
    logic [2:0] deb_pitch;

    assign raw_vec   = {note_keys, pitch_sw};
    assign deb_note  = deb_vec[9:3];
    assign deb_pitch = deb_vec[2:0];

    // Isolate the lowest-index high key so simultaneous presses resolve to one.
    assign lowest = deb_note & (~deb_note + 7'd1);

    for (genvar g = 0; g < 10; g++) begin : g_deb
        key_input_conditioner_deb #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (raw_vec[g]),
            .dout (deb_vec[g])
        );
    end

    state_t           state_q, state_d;
    logic [6:0]       key_q, key_d;
    logic [2:0]       pitch_q, pitch_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [9:0]       out_d;
    logic             press_d, rel_d, multi_d;
    logic             accept;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        pitch_d = pitch_q;
        gap_d   = gap_q;
        out_d   = '0;
        press_d = 1'b0;
        rel_d   = 1'b0;
        multi_d = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: accept = |deb_note;
            HELD: begin
                if ((deb_note & key_q) == 7'd0) begin
                    state_d = GAP;
                    gap_d   = '0;
                    rel_d   = 1'b1;
                end else begin
                    out_d   = {key_q, pitch_q};
                    multi_d = |(deb_note & ~key_q);
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (|deb_note) accept = 1'b1;
                    else           state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = HELD;
            key_d   = lowest;
            pitch_d = deb_pitch;
            out_d   = {lowest, deb_pitch};
            press_d = 1'b1;
            multi_d = |(deb_note & ~lowest);
        end
    end

    // State and output registers; reset drops outputs without a release strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            key_q          <= '0;
            pitch_q        <= '0;
            gap_q          <= '0;
            note_and_pitch <= '0;
            press_pulse    <= 1'b0;
            release_pulse  <= 1'b0;
            multi_key      <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_q          <= key_d;
            pitch_q        <= pitch_d;
            gap_q          <= gap_d;
            note_and_pitch <= out_d;
            press_pulse    <= press_d;
            release_pulse  <= rel_d;
            multi_key      <= multi_d;
        end
    end
endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner: directed scenarios plus random key
// activity, every cycle compared against a window-based reference model.

module tb_key_input_conditioner;
    localparam int D   = 4;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] note_keys;
    logic [2:0] pitch_sw;
    logic [9:0] note_and_pitch;
    logic       press_pulse, release_pulse, multi_key;

    int n_asrt = 0;
    int n_fail = 0;

    key_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .note_keys     (note_keys),
        .pitch_sw      (pitch_sw),
        .note_and_pitch(note_and_pitch),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .multi_key     (multi_key)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [9:0] hist[$];
    logic [6:0] m_deb_n;
    logic [2:0] m_deb_p;
    int         m_mode;   // 0 idle, 1 holding a note, 2 forced silence
    int         m_left;
    logic [6:0] m_key;
    logic [2:0] m_pit;
    logic [9:0] e_out;
    logic       e_press, e_rel, e_multi;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(10'd0);
        m_deb_n = '0; m_deb_p = '0;
        m_mode = 0; m_left = 0; m_key = '0; m_pit = '0;
        e_out = '0; e_press = 0; e_rel = 0; e_multi = 0;
    endtask

    // One clock edge of the model: the key/gap rules act on the debounced
    // levels visible before the edge, then the debounced levels update.
    task automatic model_edge(input logic [6:0] n, input logic [2:0] p);
        logic       acc;
        int         idx;
        logic [9:0] cur, w;
        logic       flip;
        e_press = 0; e_rel = 0; e_multi = 0; acc = 0;
        case (m_mode)
            0: acc = (m_deb_n != 0);
            1: begin
                if ((m_deb_n & m_key) == 0) begin
                    m_mode = 2; m_left = GAP - 1; e_rel = 1; e_out = '0;
                end else begin
                    e_multi = ((m_deb_n & ~m_key) != 0);
                end
            end
            default: begin
                if (m_left == 0) begin
                    if (m_deb_n != 0) acc = 1;
                    else m_mode = 0;
                end else begin
                    m_left--;
                end
            end
        endcase
        if (acc) begin
            idx = 0;
            for (int i = 6; i >= 0; i--) if (m_deb_n[i]) idx = i;
            m_key = '0; m_key[idx] = 1'b1;
            m_pit = m_deb_p; m_mode = 1;
            e_out = {m_key, m_pit}; e_press = 1;
            e_multi = ((m_deb_n & ~m_key) != 0);
        end
        // A level is accepted once the raw samples taken 2..D+1 edges ago
        // all disagree with the current debounced level.
        hist.push_back({n, p});
        if (hist.size() > D + 2) void'(hist.pop_front());
        cur = {m_deb_n, m_deb_p};
        for (int b = 0; b < 10; b++) begin
            flip = 1;
            for (int j = 0; j < D; j++) begin
                w = hist[j];
                if (w[b] == cur[b]) flip = 0;
            end
            if (flip) cur[b] = ~cur[b];
        end
        m_deb_n = cur[9:3]; m_deb_p = cur[2:0];
    endtask

    task automatic cycle(input logic [6:0] n, input logic [2:0] p);
        note_keys = n; pitch_sw = p;
        @(posedge clk);
        model_edge(n, p);
        #1;
        chk("note_and_pitch", note_and_pitch, e_out);
        chk("press_pulse", {9'd0, press_pulse}, {9'd0, e_press});
        chk("release_pulse", {9'd0, release_pulse}, {9'd0, e_rel});
        chk("multi_key", {9'd0, multi_key}, {9'd0, e_multi});
    endtask

    task automatic hold(input logic [6:0] n, input logic [2:0] p, input int len);
        for (int i = 0; i < len; i++) cycle(n, p);
    endtask

    initial begin
        rst_n = 1'b0; note_keys = '0; pitch_sw = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", note_and_pitch, 10'd0);
        chk("reset_strobes", {7'd0, press_pulse, release_pulse, multi_key}, 10'd0);
        rst_n = 1'b1;
        model_reset();

        // Clean press and release
        hold(7'b0000100, 3'b010, 6);
        chk("clean_before_edge6", note_and_pitch, 10'd0);
        cycle(7'b0000100, 3'b010);
        chk("clean_press_word", note_and_pitch, 10'b0000100_010);
        chk("clean_press_pulse", {9'd0, press_pulse}, 10'd1);
        cycle(7'b0000100, 3'b010);
        chk("clean_press_one_cycle", {9'd0, press_pulse}, 10'd0);
        hold(7'b0000100, 3'b010, 3);
        hold(7'b0000000, 3'b010, 6);
        cycle(7'b0000000, 3'b010);
        chk("clean_release_word", note_and_pitch, 10'd0);
        chk("clean_release_pulse", {9'd0, release_pulse}, 10'd1);
        hold(7'b0000000, 3'b010, 6);

        // Bounce rejection, then a clean accept
        for (int r = 0; r < 5; r++) begin
            hold(7'b0000001, 3'b000, 3);
            hold(7'b0000000, 3'b000, 1);
        end
        chk("bounce_rejected", note_and_pitch, 10'd0);
        hold(7'b0000001, 3'b000, 6);
        cycle(7'b0000001, 3'b000);
        chk("bounce_final_accept", note_and_pitch, 10'b0000001_000);
        hold(7'b0000000, 3'b000, 12);

        // Arbitration and re-arbitration after the gap
        hold(7'b0010100, 3'b000, 6);
        cycle(7'b0010100, 3'b000);
        chk("arb_lowest", {3'd0, note_and_pitch[9:3]}, 10'b0000000100);
        chk("arb_multi", {9'd0, multi_key}, 10'd1);
        hold(7'b1010100, 3'b000, 8);
        chk("arb_ignore_new", {3'd0, note_and_pitch[9:3]}, 10'b0000000100);
        hold(7'b1010000, 3'b000, 6);
        cycle(7'b1010000, 3'b000);
        chk("arb_release", {9'd0, release_pulse}, 10'd1);
        cycle(7'b1010000, 3'b000);
        chk("arb_gap2", note_and_pitch, 10'd0);
        cycle(7'b1010000, 3'b000);
        chk("arb_next_key", {3'd0, note_and_pitch[9:3]}, 10'b0000010000);
        chk("arb_next_press", {9'd0, press_pulse}, 10'd1);
        hold(7'b0000000, 3'b000, 12);

        // Pitch is latched at press
        hold(7'b0000010, 3'b001, 7);
        chk("pitch_latch", note_and_pitch, 10'b0000010_001);
        hold(7'b0000010, 3'b100, 10);
        chk("pitch_ignored", note_and_pitch, 10'b0000010_001);
        hold(7'b0000000, 3'b100, 12);
        hold(7'b0000001, 3'b100, 7);
        chk("pitch_fresh", note_and_pitch, 10'b0000001_100);
        hold(7'b0000000, 3'b100, 12);

        // Roll-over: release one key and press another in the same cycle
        hold(7'b0001000, 3'b011, 7);
        hold(7'b0100000, 3'b011, 6);
        cycle(7'b0100000, 3'b011);
        chk("roll_release", {8'd0, release_pulse, |note_and_pitch}, 10'b10);
        cycle(7'b0100000, 3'b011);
        chk("roll_gap2", note_and_pitch, 10'd0);
        cycle(7'b0100000, 3'b011);
        chk("roll_new", note_and_pitch, 10'b0100000_011);
        hold(7'b0000000, 3'b011, 12);

        // Reset while a note is held
        hold(7'b0000100, 3'b101, 8);
        chk("rst_pre_held", note_and_pitch, 10'b0000100_101);
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", note_and_pitch, 10'd0);
        chk("rst_async_strobes", {7'd0, press_pulse, release_pulse, multi_key}, 10'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        hold(7'b0000100, 3'b101, 6);
        chk("rst_no_early", note_and_pitch, 10'd0);
        cycle(7'b0000100, 3'b101);
        chk("rst_repress", {9'd0, press_pulse}, 10'd1);
        chk("rst_repress_word", note_and_pitch, 10'b0000100_101);
        hold(7'b0000000, 3'b101, 12);

        // Random key activity against the model
        for (int s = 0; s < 300; s++) begin
            logic [6:0] n;
            logic [2:0] p;
            case ($urandom_range(0, 3))
                0:       n = 7'd0;
                1:       begin n = 7'd0; n[$urandom_range(0, 6)] = 1'b1; end
                default: n = 7'($urandom_range(0, 127));
            endcase
            p = 3'($urandom_range(0, 7));
            hold(n, p, $urandom_range(1, 12));
        end
        hold(7'b0000000, 3'b000, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
